// File: rtl/bus_sync_capture.sv
// bus_sync_capture: qualifies a quasi-static source-domain bus using an
// already-synchronized enable bit. Each accepted enable event captures the
// bus, emits a one-cycle pulse and holds the word under a valid/ready
// handshake. Events arriving while a word is still unconsumed are dropped
// and flagged on the sticky OVERRUN output.
module bus_sync_capture #(
  parameter int BUS_WIDTH   = 8,
  parameter int TOGGLE_MODE = 0,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SYNC_EN,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 RDY_IN,
  input  logic                 CLR_ERR,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 DATA_VLD,
  output logic                 OVERRUN,
  output logic [CNT_WIDTH-1:0] EVT_CNT
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_q;
  logic                 prev_q;
  logic [BUS_WIDTH-1:0] bus_q;
  logic                 pulse_q;
  logic                 vld_q;
  logic                 ovr_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic evt;
  logic xfer;

  // Event detect; suppressed in INIT so a high enable out of reset is not an event.
  always_comb begin
    evt = 1'b0;
    if (state_q != INIT) begin
      if (TOGGLE_MODE != 0) begin
        evt = SYNC_EN ^ prev_q;
      end else begin
        evt = SYNC_EN & ~prev_q;
      end
    end
    xfer = vld_q & RDY_IN;
  end

  // Capture FSM with registered outputs; a drop in the same cycle as CLR_ERR keeps OVERRUN set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= INIT;
      prev_q  <= 1'b0;
      bus_q   <= '0;
      pulse_q <= 1'b0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      prev_q  <= SYNC_EN;
      pulse_q <= 1'b0;
      if (CLR_ERR) begin
        ovr_q <= 1'b0;
      end
      case (state_q)
        INIT: begin
          state_q <= IDLE;
        end
        IDLE: begin
          if (evt) begin
            bus_q   <= UNSYNC_BUS;
            pulse_q <= 1'b1;
            cnt_q   <= cnt_q + CNT_WIDTH'(1);
            vld_q   <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (evt && xfer) begin
            bus_q   <= UNSYNC_BUS;
            pulse_q <= 1'b1;
            cnt_q   <= cnt_q + CNT_WIDTH'(1);
          end else if (evt) begin
            ovr_q <= 1'b1;
          end else if (xfer) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= INIT;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign SYNC_BUS     = bus_q;
  assign ENABLE_PULSE = pulse_q;
  assign DATA_VLD     = vld_q;
  assign OVERRUN      = ovr_q;
  assign EVT_CNT      = cnt_q;

endmodule

// File: tb/tb_bus_sync_capture.sv
// Bench for bus_sync_capture: two instances share one stimulus stream
// (index 0: rising-edge mode, 8-bit counter; index 1: toggle mode, 4-bit
// counter). A word-level model tracks each instance and is compared every
// cycle; directed scenarios add hand-computed literal checks.
module tb_bus_sync_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync_en = 1'b0;
  logic [7:0] ubus = 8'h00;
  logic       rdy = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] sb0, sb1;
  logic       ep0, ep1, dv0, dv1, ov0, ov1;
  logic [7:0] cnt0;
  logic [3:0] cnt1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  bus_sync_capture #(.BUS_WIDTH(8), .TOGGLE_MODE(0), .CNT_WIDTH(8)) dut0 (
    .CLK(clk), .RST(rst), .SYNC_EN(sync_en), .UNSYNC_BUS(ubus), .RDY_IN(rdy),
    .CLR_ERR(clr), .SYNC_BUS(sb0), .ENABLE_PULSE(ep0), .DATA_VLD(dv0),
    .OVERRUN(ov0), .EVT_CNT(cnt0));

  bus_sync_capture #(.BUS_WIDTH(8), .TOGGLE_MODE(1), .CNT_WIDTH(4)) dut1 (
    .CLK(clk), .RST(rst), .SYNC_EN(sync_en), .UNSYNC_BUS(ubus), .RDY_IN(rdy),
    .CLR_ERR(clr), .SYNC_BUS(sb1), .ENABLE_PULSE(ep1), .DATA_VLD(dv1),
    .OVERRUN(ov1), .EVT_CNT(cnt1));

  // Word-level model: a pending word, a running count of accepted events,
  // and a sticky drop flag. The first cycle after reset only learns the level.
  logic [7:0] m_word[2];
  bit         m_pend[2], m_pulse[2], m_ovr[2], m_prev[2], m_armed[2];
  int         m_cnt[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_word[k] = 8'h00; m_pend[k] = 0; m_pulse[k] = 0; m_ovr[k] = 0;
        m_prev[k] = 0; m_armed[k] = 0; m_cnt[k] = 0;
      end else begin
        bit e, taken;
        e = m_armed[k] && ((k == 1) ? (sync_en != m_prev[k]) : (sync_en && !m_prev[k]));
        taken = m_pend[k] && rdy;
        m_pulse[k] = 0;
        if (clr) m_ovr[k] = 0;
        if (e && (!m_pend[k] || taken)) begin
          m_word[k] = ubus; m_pulse[k] = 1; m_cnt[k] = m_cnt[k] + 1; m_pend[k] = 1;
        end else if (e) begin
          m_ovr[k] = 1;
        end else if (taken) begin
          m_pend[k] = 0;
        end
        m_prev[k] = sync_en;
        m_armed[k] = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_bus0", {24'd0, sb0}, {24'd0, m_word[0]});
      chk("m_pulse0", {31'd0, ep0}, {31'd0, m_pulse[0]});
      chk("m_vld0", {31'd0, dv0}, {31'd0, m_pend[0]});
      chk("m_ovr0", {31'd0, ov0}, {31'd0, m_ovr[0]});
      chk("m_cnt0", {24'd0, cnt0}, 32'(m_cnt[0] % 256));
      chk("m_bus1", {24'd0, sb1}, {24'd0, m_word[1]});
      chk("m_pulse1", {31'd0, ep1}, {31'd0, m_pulse[1]});
      chk("m_vld1", {31'd0, dv1}, {31'd0, m_pend[1]});
      chk("m_ovr1", {31'd0, ov1}, {31'd0, m_ovr[1]});
      chk("m_cnt1", {28'd0, cnt1}, 32'(m_cnt[1] % 16));
      if (m_pulse[0]) $display("capture dut0 word=%h cnt=%0d", m_word[0], m_cnt[0] % 256);
      if (m_pulse[1]) $display("capture dut1 word=%h cnt=%0d", m_word[1], m_cnt[1] % 16);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1; clr = 0; rdy = 0; sync_en = 0;
    cyc();
    rst = 0;
    cyc();  // INIT edge
  endtask

  initial begin
    // Reset with enable already high; no event may appear afterwards.
    rst = 1; sync_en = 1; ubus = 8'hA5; rdy = 0; clr = 0;
    cyc();
    cmp_en = 1;
    cyc();
    chk("rst_bus0", {24'd0, sb0}, 32'h0);
    chk("rst_vld1", {31'd0, dv1}, 32'h0);
    chk("rst_cnt1", {28'd0, cnt1}, 32'h0);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("quiet_pulse0", {31'd0, ep0}, 32'h0);
      chk("quiet_pulse1", {31'd0, ep1}, 32'h0);
      chk("quiet_vld0", {31'd0, dv0}, 32'h0);
      chk("quiet_cnt0", {24'd0, cnt0}, 32'h0);
    end

    // Rising-edge capture on dut0; falling edge is not an event.
    do_reset();
    rdy = 1; ubus = 8'h3C; sync_en = 0;
    cyc();
    sync_en = 1;
    cyc();
    chk("rise_bus0", {24'd0, sb0}, 32'h3C);
    chk("rise_pulse0", {31'd0, ep0}, 32'h1);
    chk("rise_cnt0", {24'd0, cnt0}, 32'd1);
    chk("rise_vld0", {31'd0, dv0}, 32'h1);
    cyc();
    chk("rise_pulse0_off", {31'd0, ep0}, 32'h0);
    chk("rise_vld0_off", {31'd0, dv0}, 32'h0);
    sync_en = 0;
    cyc(); cyc();
    chk("fall_cnt0", {24'd0, cnt0}, 32'd1);
    chk("fall_pulse0", {31'd0, ep0}, 32'h0);

    // Toggle mode on dut1 with consumer stalled: second event dropped.
    do_reset();
    ubus = 8'h11; sync_en = 1;
    cyc();
    chk("t_bus1_first", {24'd0, sb1}, 32'h11);
    chk("t_pulse1_first", {31'd0, ep1}, 32'h1);
    ubus = 8'h22; sync_en = 0;
    cyc();
    chk("drop_bus1", {24'd0, sb1}, 32'h11);
    chk("drop_pulse1", {31'd0, ep1}, 32'h0);
    chk("drop_ovr1", {31'd0, ov1}, 32'h1);
    chk("drop_cnt1", {28'd0, cnt1}, 32'd1);
    rdy = 1;
    cyc();
    chk("drain_vld1", {31'd0, dv1}, 32'h0);
    chk("drain_ovr1", {31'd0, ov1}, 32'h1);
    rdy = 0; clr = 1;
    cyc();
    clr = 0;
    chk("clr_ovr1", {31'd0, ov1}, 32'h0);

    // Replace a held word in the same cycle it is consumed.
    ubus = 8'h44; sync_en = 1;
    cyc();
    chk("hold_bus1", {24'd0, sb1}, 32'h44);
    rdy = 1; ubus = 8'h55; sync_en = 0;
    cyc();
    chk("swap_bus1", {24'd0, sb1}, 32'h55);
    chk("swap_vld1", {31'd0, dv1}, 32'h1);
    chk("swap_pulse1", {31'd0, ep1}, 32'h1);
    chk("swap_cnt1", {28'd0, cnt1}, 32'd3);

    // 17 back-to-back events on dut1: continuous pulse, 4-bit count wraps to 1.
    do_reset();
    rdy = 1;
    for (int i = 1; i <= 17; i++) begin
      ubus = 8'(i); sync_en = ~sync_en;
      cyc();
      chk("b2b_pulse1", {31'd0, ep1}, 32'h1);
    end
    chk("wrap_cnt1", {28'd0, cnt1}, 32'd1);
    chk("wrap_bus1", {24'd0, sb1}, 32'h11);
    // Drop coinciding with CLR_ERR: drop wins.
    rdy = 0; clr = 1; ubus = 8'h99; sync_en = ~sync_en;
    cyc();
    clr = 0;
    chk("drop_clr_ovr1", {31'd0, ov1}, 32'h1);
    chk("drop_clr_bus1", {24'd0, sb1}, 32'h11);

    // Reset while a word is pending discards it with no pulse.
    rdy = 1;
    cyc();
    rdy = 0; ubus = 8'hF0; sync_en = ~sync_en;
    cyc();
    chk("pend_bus1", {24'd0, sb1}, 32'hF0);
    rst = 1; sync_en = ~sync_en;
    cyc();
    chk("mid_rst_bus1", {24'd0, sb1}, 32'h0);
    chk("mid_rst_vld1", {31'd0, dv1}, 32'h0);
    chk("mid_rst_pulse1", {31'd0, ep1}, 32'h0);
    chk("mid_rst_ovr1", {31'd0, ov1}, 32'h0);
    chk("mid_rst_cnt1", {28'd0, cnt1}, 32'h0);
    rst = 0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_sync_capture.md
# bus_sync_capture

Downstream companion to the multi-flop synchronizer: consumes its already-synchronized enable bit and qualifies a quasi-static multi-bit bus from the source clock domain. On each enable event it captures the bus into a destination-domain register and emits a one-cycle enable pulse. It holds the word under a valid/ready handshake to the consumer, and flags events that arrive while the previous word is still unconsumed.

## Interface
- BUS_WIDTH, 8, width of captured data bus
- TOGGLE_MODE, 0, 0: event = rising edge of SYNC_EN; 1: event = any transition of SYNC_EN
- CNT_WIDTH, 8, width of accepted-event counter
- CLK  input  1  destination-domain clock
- RST  input  1  reset, synchronous, active-high; one clock domain (CLK) only
- SYNC_EN  input  1  enable bit already synchronized to CLK by the upstream multi-flop synchronizer
- UNSYNC_BUS  input  BUS_WIDTH  source-domain bus; source guarantees it is stable from before its enable changes until after the next event
- RDY_IN  input  1  consumer ready
- CLR_ERR  input  1  clears OVERRUN
- SYNC_BUS  output  BUS_WIDTH  captured data, registered
- ENABLE_PULSE  output  1  one-cycle pulse, high in the cycle after a capture
- DATA_VLD  output  1  SYNC_BUS holds an unconsumed word
- OVERRUN  output  1  sticky: an event was dropped
- EVT_CNT  output  CNT_WIDTH  count of accepted captures, wraps

## Operation
- FSM states: INIT, IDLE, HOLD. RST high at a CLK edge: state <= INIT.
- Reset values (all outputs): SYNC_BUS=0, ENABLE_PULSE=0, DATA_VLD=0, OVERRUN=0, EVT_CNT=0. The internal prev register is 0.
- INIT:
  - lasts exactly one cycle; prev <= SYNC_EN; no event is detected.
  - Next state is IDLE. This prevents a spurious event when SYNC_EN is already high out of reset.
- Event definition, evaluated in IDLE/HOLD:
  - TOGGLE_MODE=0: evt = SYNC_EN & ~prev.
  - TOGGLE_MODE=1: evt = SYNC_EN ^ prev.
  - prev <= SYNC_EN every cycle outside reset.
- Transfer: xfer = DATA_VLD & RDY_IN.
- IDLE + evt: SYNC_BUS <= UNSYNC_BUS, ENABLE_PULSE <= 1, EVT_CNT++, then go to HOLD.
- IDLE, no evt: outputs hold, ENABLE_PULSE <= 0.
- HOLD cases:
  - xfer & ~evt: go to IDLE.
  - xfer & evt: capture new word, pulse, EVT_CNT++, stay in HOLD.
  - ~xfer & evt: event dropped; SYNC_BUS unchanged, no pulse, EVT_CNT unchanged, OVERRUN <= 1.
  - ~xfer & ~evt: hold.
- DATA_VLD = (state == HOLD), registered.
- OVERRUN:
  - sticky until CLR_ERR=1.
  - A new drop in the same cycle as CLR_ERR wins, so OVERRUN stays 1.
- EVT_CNT wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- RST asserted mid-operation (any state, including HOLD with pending data):
  - all state is discarded at that edge.
  - the pending word is lost and no pulse is emitted.

## Timing
- Capture latency: evt sampled at edge k → SYNC_BUS, DATA_VLD, ENABLE_PULSE valid after edge k. End-to-end from source enable is NUM_STAGES+1 CLK edges.
- ENABLE_PULSE is high for exactly one cycle per accepted event. It is never high for dropped events.
- Back-to-back events (TOGGLE_MODE=1, SYNC_EN toggling every cycle) with RDY_IN held 1 give a capture every cycle and a continuous pulse.
- Consumer handshake: a word is consumed at the edge where DATA_VLD & RDY_IN. RDY_IN is ignored while DATA_VLD=0.
- First detectable event is at the second edge after RST deasserts.

## Test plan
- Reset with SYNC_EN=1 held, UNSYNC_BUS=8'hA5; release RST → no ENABLE_PULSE, DATA_VLD=0, EVT_CNT=0 for 10 cycles.
- TOGGLE_MODE=0, RDY_IN=1, UNSYNC_BUS=8'h3C, SYNC_EN 0→1 → next cycle SYNC_BUS=8'h3C, ENABLE_PULSE=1 for one cycle, EVT_CNT=1. SYNC_EN 1→0 produces no event.
- TOGGLE_MODE=1, RDY_IN=0, events with buses 8'h11, then 8'h22 → SYNC_BUS stays 8'h11, OVERRUN=1, EVT_CNT=1, one pulse only. Assert RDY_IN → DATA_VLD drops next cycle. Pulse CLR_ERR → OVERRUN=0.
- HOLD with RDY_IN=1 and evt in the same cycle (bus 8'h55 replacing 8'h44) → SYNC_BUS=8'h55, DATA_VLD stays 1, pulse, EVT_CNT +1.
- CNT_WIDTH=4, 17 accepted events → EVT_CNT=1 (wrap). Simultaneous drop and CLR_ERR → OVERRUN=1.
- RST asserted while in HOLD with 8'hF0 pending → next cycle all outputs 0; no pulse.
